// File: rtl/my_memory.sv
// Hack data-memory responder: RAM, screen and keyboard behind the CPU M-port,
// plus a screen scan-out engine that serialises screen words into pixels.
module my_memory #(
  parameter int RAM_WORDS     = 16384,
  parameter int SCREEN_WORDS  = 8192,
  parameter int WORDS_PER_ROW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  output logic        pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        dbg_state_o
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int SCR_AW = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_STREAM = 1'b1
  } scan_state_e;

  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] scr_q [SCREEN_WORDS];
  logic [15:0] kbd_q;

  logic              ram_hit;
  logic              scr_hit;
  logic              kbd_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;

  scan_state_e       state_q, state_d;
  logic [SCR_AW-1:0] word_idx_q, word_idx_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              handshake;

  // Indices past the implemented depth fall through to the unmapped (zero) case.
  always_comb begin
    ram_hit = (addressM[14] == 1'b0) && (32'(addressM[13:0]) < RAM_WORDS);
    scr_hit = (addressM[14:13] == 2'b10) && (32'(addressM[12:0]) < SCREEN_WORDS);
    kbd_hit = (addressM == 15'h6000);
    ram_idx = addressM[RAM_AW-1:0];
    scr_idx = addressM[SCR_AW-1:0];
  end

  always_comb begin
    inM = 16'h0000;
    if (ram_hit)      inM = ram_q[ram_idx];
    else if (scr_hit) inM = scr_q[scr_idx];
    else if (kbd_hit) inM = kbd_q;
  end

  // Arrays are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (reset && writeM) begin
      if (ram_hit) ram_q[ram_idx] <= outM;
      if (scr_hit) scr_q[scr_idx] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) kbd_q <= 16'h0000;
    else        kbd_q <= kbd_code;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      word_idx_q <= '0;
      bit_idx_q  <= 4'd0;
      shreg_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  // A pixel transfers on an edge where pix_valid and pix_ready are both high;
  // otherwise the source holds pix_data/pix_sof/pix_eol stable.
  assign handshake = pix_valid & pix_ready;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    case (state_q)
      ST_LOAD: begin
        shreg_d = scr_q[word_idx_q];
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (bit_idx_q == 4'd15) begin
            bit_idx_d  = 4'd0;
            word_idx_d = (32'(word_idx_q) == SCREEN_WORDS - 1) ? '0
                                                               : word_idx_q + SCR_AW'(1);
            // Fetch in the same edge so sustained ready streams without a bubble.
            shreg_d    = scr_q[word_idx_d];
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    pix_valid   = reset && (state_q == ST_STREAM);
    pix_data    = pix_valid && shreg_q[bit_idx_q];
    pix_sof     = pix_valid && (word_idx_q == '0) && (bit_idx_q == 4'd0);
    pix_eol     = pix_valid && (bit_idx_q == 4'd15) &&
                  ((32'(word_idx_q) % WORDS_PER_ROW) == WORDS_PER_ROW - 1);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_my_memory.sv
// Directed + randomised bench for my_memory, checked against a pixel-position
// reference model of the memory map and the scan-out stream.
module tb_my_memory;

  localparam int RW   = 64;
  localparam int SW   = 4;
  localparam int WPR  = 2;
  localparam int NPIX = SW * 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        pix_data, pix_valid, pix_ready, pix_sof, pix_eol;
  logic        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] ram_m [RW];
  logic [15:0] scr_m [SW];
  logic [15:0] kbd_m;
  bit          m_active;
  int          m_pos;
  logic [15:0] m_word;
  bit          mem_init = 1'b0;

  always #5 clk = ~clk;

  my_memory #(.RAM_WORDS(RW), .SCREEN_WORDS(SW), .WORDS_PER_ROW(WPR)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_code(kbd_code), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .dbg_state_o(dbg_state)
  );

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_inm(input logic [14:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h4000)       return (ai < RW) ? ram_m[ai] : 16'h0000;
    else if (ai < 'h6000)  return (ai - 'h4000 < SW) ? scr_m[ai - 'h4000] : 16'h0000;
    else if (ai == 'h6000) return kbd_m;
    return 16'h0000;
  endfunction

  task automatic check_all();
    bit v;
    v = m_active && (reset === 1'b1);
    cmp("pix_valid", {15'b0, pix_valid}, {15'b0, v});
    cmp("pix_sof", {15'b0, pix_sof}, {15'b0, v && (m_pos == 0)});
    cmp("pix_eol", {15'b0, pix_eol},
        {15'b0, v && (m_pos % 16 == 15) && ((m_pos / 16) % WPR == WPR - 1)});
    if (mem_init) begin
      cmp("inM", inM, exp_inm(addressM));
      cmp("pix_data", {15'b0, pix_data}, {15'b0, v ? m_word[m_pos % 16] : 1'b0});
    end
  endtask

  // Model advances on the clock edge using the pre-edge inputs; the scanner
  // fetch sees array contents before that edge's CPU write.
  task automatic model_edge();
    int a;
    if (!reset) begin
      m_active = 1'b0;
      kbd_m    = 16'h0000;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_word   = scr_m[0];
      end else if (pix_ready) begin
        m_pos = (m_pos + 1) % NPIX;
        if (m_pos % 16 == 0) m_word = scr_m[m_pos / 16];
      end
      if (writeM) begin
        a = int'(addressM);
        if (a < RW) ram_m[a] = outM;
        else if (a >= 'h4000 && a < 'h4000 + SW) scr_m[a - 'h4000] = outM;
      end
      kbd_m = kbd_code;
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [15:0] w0, w1, old_w;
    reset = 1'b0; addressM = '0; outM = '0; writeM = 1'b0;
    kbd_code = '0; pix_ready = 1'b0;
    m_active = 1'b0; m_pos = 0; kbd_m = '0; m_word = 'x;
    for (int i = 0; i < RW; i++) ram_m[i] = 'x;
    for (int i = 0; i < SW; i++) scr_m[i] = 'x;

    repeat (2) cycle();
    reset = 1'b1;
    for (int i = 0; i < RW; i++) begin
      addressM = 15'(i); outM = 16'($urandom); writeM = 1'b1; cycle();
    end
    for (int i = 0; i < SW; i++) begin
      addressM = 15'('h4000 + i); outM = 16'($urandom); writeM = 1'b1; cycle();
    end
    writeM = 1'b0;
    mem_init = 1'b1;

    // Reset and restart of the scan engine
    reset = 1'b0;
    cycle();
    #1 cmp("rst_valid", {15'b0, pix_valid}, 16'd0);
    cycle();
    reset = 1'b1;
    #1 cmp("load_valid", {15'b0, pix_valid}, 16'd0);
    cycle();
    cmp("first_valid", {15'b0, pix_valid}, 16'd1);
    cmp("first_sof", {15'b0, pix_sof}, 16'd1);

    // RAM and unmapped accesses
    addressM = 15'h0010; outM = 16'h1234; writeM = 1'b1; cycle();
    writeM = 1'b0;
    #1 cmp("ram_rd", inM, 16'h1234);
    addressM = 15'h6001;
    #1 cmp("unmapped_rd", inM, 16'h0000);
    addressM = 15'h7000; outM = 16'hBEEF; writeM = 1'b1; cycle();
    writeM = 1'b0;
    #1 cmp("unmapped_wr", inM, 16'h0000);
    addressM = 15'h0040; outM = 16'hDEAD; writeM = 1'b1; cycle();
    writeM = 1'b0;
    #1 cmp("ram_oob_rd", inM, 16'h0000);
    addressM = 15'h0000;
    #1 cmp("ram0_kept", inM, ram_m[0]);
    addressM = 15'h4004; outM = 16'hCAFE; writeM = 1'b1; cycle();
    writeM = 1'b0;
    #1 cmp("scr_oob_rd", inM, 16'h0000);
    addressM = 15'h0010;
    #1 cmp("ram_kept", inM, 16'h1234);
    cycle();

    // Keyboard latch latency
    kbd_code = 16'h0041; addressM = 15'h6000;
    #1 cmp("kbd_same", inM, 16'h0000);
    cycle();
    cmp("kbd_next", inM, 16'h0041);
    kbd_code = 16'h0000;
    #1 cmp("kbd_hold", inM, 16'h0041);
    cycle();
    cmp("kbd_clr", inM, 16'h0000);

    // Known pattern, sustained ready, no bubbles
    w0 = 16'h0005; w1 = 16'h8000;
    addressM = 15'h4000; outM = w0; writeM = 1'b1; cycle();
    addressM = 15'h4001; outM = w1; cycle();
    writeM = 1'b0; reset = 1'b0; cycle();
    reset = 1'b1; cycle();
    pix_ready = 1'b1;
    for (int p = 0; p < 32; p++) begin
      #1;
      cmp("pix_seq", {15'b0, pix_data}, {15'b0, (p < 16) ? w0[p] : w1[p - 16]});
      cmp("pix_seq_valid", {15'b0, pix_valid}, 16'd1);
      cycle();
    end

    // Random traffic with random backpressure
    for (int n = 0; n < 700; n++) begin
      pix_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       addressM = 15'($urandom_range(0, RW + 3));
        1:       addressM = 15'('h4000 + $urandom_range(0, SW + 1));
        2:       addressM = 15'h6000;
        3:       addressM = 15'h6001;
        4:       addressM = 15'('h7000 + $urandom_range(0, 255));
        default: addressM = 15'($urandom_range(0, 32767));
      endcase
      writeM   = ($urandom_range(0, 3) == 0);
      outM     = 16'($urandom);
      kbd_code = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 255)) : 16'h0000;
      cycle();
    end

    // Write landing on the same edge as the fetch of that word
    writeM = 1'b0; kbd_code = '0; pix_ready = 1'b0;
    old_w = 16'h0005;
    addressM = 15'h4000; outM = old_w; writeM = 1'b1; cycle();
    writeM = 1'b0; reset = 1'b0; cycle();
    reset = 1'b1; addressM = 15'h4000; outM = 16'hFFFF; writeM = 1'b1; cycle();
    writeM = 1'b0; pix_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      #1 cmp("coh_old", {15'b0, pix_data}, {15'b0, old_w[p]});
      cycle();
    end
    repeat (NPIX - 16) cycle();
    cmp("coh_sof", {15'b0, pix_sof}, 16'd1);
    for (int p = 0; p < 16; p++) begin
      #1 cmp("coh_new", {15'b0, pix_data}, 16'd1);
      cycle();
    end

    // Reset in the middle of a word
    repeat (5) cycle();
    reset = 1'b0;
    #1;
    cmp("midrst_valid", {15'b0, pix_valid}, 16'd0);
    cmp("midrst_sof", {15'b0, pix_sof}, 16'd0);
    cmp("midrst_data", {15'b0, pix_data}, 16'd0);
    cycle();
    reset = 1'b1;
    #1 cmp("midrst_load", {15'b0, pix_valid}, 16'd0);
    cycle();
    cmp("midrst_restart_sof", {15'b0, pix_sof}, 16'd1);
    cmp("midrst_restart_data", {15'b0, pix_data}, 16'd1);
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
